// File: rtl/ccip_avmm_csr_slave_if.sv
// ccip_avmm_csr_slave_if: Avalon-MM bus between the MMIO bridge (master) and the CSR slave
interface ccip_avmm_csr_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  modport master (output address, read, write, writedata, byteenable,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/ccip_avmm_csr_slave.sv
// ccip_avmm_csr_slave: AFU CSR register file (DFH, AFU ID, scratch, counters, CTRL) answering
// AVMM traffic from the CCI-P MMIO bridge with a fixed-latency read pipeline.
module ccip_avmm_csr_slave #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 64,
  parameter int          RD_LATENCY  = 2,
  parameter int          INIT_CYCLES = 8,
  parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_1000,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ccip_avmm_csr_slave_if.slave avmm,
  output logic                 ctrl_enable,
  output logic                 err_sticky
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  typedef logic [DATA_WIDTH-1:0] word_t;
  logic [IW-1:0]         init_q, init_d;
  word_t                 sc0_q, sc0_d, sc1_q, sc1_d, rdata, wmerge;
  logic [31:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                  ctrl_q, ctrl_d, err_q, err_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  word_t                 dat_q [RD_LATENCY];
  word_t                 dat_d [RD_LATENCY];
  logic [3:0]            sel;
  logic                  hit, acc_any, acc_wr, acc_rd, clr;

  assign avmm.waitrequest   = init_q != '0;
  assign avmm.readdatavalid = vld_q[RD_LATENCY-1];
  assign avmm.readdata      = dat_q[RD_LATENCY-1];
  assign ctrl_enable        = ctrl_q;
  assign err_sticky         = err_q;

  always_comb begin
    sel     = avmm.address[6:3];
    hit     = avmm.address[ADDR_WIDTH-1:7] == '0 && sel <= 4'd8;
    acc_any = (avmm.read || avmm.write) && !avmm.waitrequest;
    acc_wr  = avmm.write && !avmm.waitrequest;
    acc_rd  = avmm.read && !avmm.write && !avmm.waitrequest;
    clr     = acc_wr && hit && sel == 4'd8 && avmm.byteenable[0] && avmm.writedata[1];
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      wmerge[8*i +: 8] = avmm.byteenable[i] ? avmm.writedata[8*i +: 8]
                       : (sel == 4'd5 ? sc1_q[8*i +: 8] : sc0_q[8*i +: 8]);
    rdata = '0;
    if (hit)
      case (sel)
        4'd0:    rdata = DFH_VALUE;
        4'd1:    rdata = AFU_ID_L;
        4'd2:    rdata = AFU_ID_H;
        4'd4:    rdata = sc0_q;
        4'd5:    rdata = sc1_q;
        4'd6:    rdata = {32'h0, wr_cnt_q};
        4'd7:    rdata = {32'h0, rd_cnt_q};
        4'd8:    rdata = {63'h0, ctrl_q};
        default: rdata = '0;
      endcase
    init_d   = avmm.waitrequest ? init_q - 1'b1 : init_q;
    sc0_d    = acc_wr && hit && sel == 4'd4 ? wmerge : sc0_q;
    sc1_d    = acc_wr && hit && sel == 4'd5 ? wmerge : sc1_q;
    ctrl_d   = acc_wr && hit && sel == 4'd8 && avmm.byteenable[0] ? avmm.writedata[0] : ctrl_q;
    wr_cnt_d = clr ? '0 : wr_cnt_q + {31'h0, acc_wr};
    rd_cnt_d = clr ? '0 : rd_cnt_q + {31'h0, acc_rd};
    err_d    = err_q || (acc_any && (avmm.read && avmm.write || !hit));
    // Data stages only advance behind a valid bit, so the output stage holds the last returned word.
    vld_d    = RD_LATENCY'({vld_q, acc_rd});
    dat_d[0] = acc_rd ? rdata : dat_q[0];
    for (int i = 1; i < RD_LATENCY; i++)
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      init_q   <= IW'(INIT_CYCLES);
      sc0_q    <= '0;
      sc1_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      ctrl_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      init_q   <= init_d;
      sc0_q    <= sc0_d;
      sc1_q    <= sc1_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
endmodule

// File: doc/ccip_avmm_csr_slave.md
Name: ccip_avmm_csr_slave

Overview:
- Avalon-MM slave register file that answers the MMIO-derived AVMM master traffic produced by the CCI-P MMIO bridge.
- Sits behind that bridge inside the AFU.
- Provides the AFU device feature header, AFU ID, scratch registers, access counters and a control register.
- Returns reads at a fixed pipelined latency and applies per-byte write enables, so 32-bit and 64-bit MMIO both work.

Parameters:
- ADDR_WIDTH, 16, byte address width of avmm_address.
- DATA_WIDTH, 64, data width; only 64 is supported.
- RD_LATENCY, 2, cycles from read acceptance to avmm_readdatavalid; legal range 1..4.
- INIT_CYCLES, 8, cycles avmm_waitrequest stays high after reset release; must be ≥1.
- DFH_VALUE, 64'h1000_0000_0000_1000, constant returned at offset 0x00.
- AFU_ID_L, 64'h0, constant returned at 0x08.
- AFU_ID_H, 64'h0, constant returned at 0x10.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- avmm_address  in  ADDR_WIDTH  byte address; bits [2:0] ignored for decode.
- avmm_read  in  1  read request.
- avmm_write  in  1  write request.
- avmm_writedata  in  64  write data.
- avmm_byteenable  in  8  byte lane enables.
- avmm_waitrequest  out  1  slave not ready.
- avmm_readdata  out  64  read data.
- avmm_readdatavalid  out  1  read data valid.
- ctrl_enable  out  1  CTRL[0].
- err_sticky  out  1  protocol/decode error flag.

Behaviour:
- **Reset** (async assert, sync release):
  - avmm_waitrequest=1, avmm_readdatavalid=0, avmm_readdata=0.
  - SCRATCH0/1=0, counters=0, CTRL=0, err_sticky=0, init counter=INIT_CYCLES.
- **Init:** counter decrements each cycle after release; waitrequest deasserts the cycle the counter reaches 0 and stays low until the next reset.
- **Acceptance:** a request is accepted when (read|write) && !waitrequest. Requests presented while waitrequest=1 have no effect and set nothing.
- **Register map** (byte offset = address & ~7):
  - 0x00 DFH, RO.
  - 0x08 AFU_ID_L, RO.
  - 0x10 AFU_ID_H, RO.
  - 0x18 reserved, RO, reads 0.
  - 0x20 SCRATCH0, RW.
  - 0x28 SCRATCH1, RW.
  - 0x30 WR_COUNT, RO: bits[31:0] count accepted writes, bits[63:32]=0.
  - 0x38 RD_COUNT, RO: same format for accepted reads.
  - 0x40 CTRL, RW bit0 only, other bits read 0; bit1 is write-1 action "clear counters" and reads 0.
  - Any other offset reads 0; writes to it are ignored and set err_sticky.
- **Writes:**
  - Byte lane i is updated only where byteenable[i]=1; e.g. be=8'hF0 updates bits[63:32] only.
  - New value is visible to a read accepted the following cycle.
  - Writes to RO offsets are ignored without error.
- **CTRL clear:** a write to 0x40 with be[0]=1 and data[1]=1 zeroes both counters.
  - The clearing write itself is not counted (clear wins).
  - A read accepted in the same cycle is also not counted.
- **Counters:** 32-bit, wrap 0xFFFF_FFFF→0. Increment on acceptance regardless of address validity.
- **Reads:**
  - Data is sampled in the acceptance cycle and driven on avmm_readdata with avmm_readdatavalid=1 exactly RD_LATENCY cycles later, via a RD_LATENCY-deep shift pipeline.
  - Back-to-back reads, one per cycle, are supported with no bubbles.
  - avmm_readdata holds its last value when valid=0.
  - Byteenable is ignored on reads; the full 64 bits are returned.
  - A RD_COUNT read returns the value before its own increment.
- **Simultaneous read & write accepted:** the write executes, the read is dropped (no readdatavalid, not counted), and err_sticky is set.
- **err_sticky:** cleared only by reset.
- **Reset mid-operation:** in-flight reads are discarded and readdatavalid=0 immediately (async).

Test Plan:
- **Reset/init:** release reset with read held high → waitrequest=1 for exactly 8 cycles; then read 0x00 → readdatavalid 2 cycles after acceptance, data=64'h1000_0000_0000_1000.
- **Byte-lane write:**
  - Write 0x20 data=64'h1111_2222_3333_4444 be=FF, then write data=64'hAAAA_BBBB_CCCC_DDDD be=F0 → read 0x20 returns 64'hAAAA_BBBB_3333_4444.
  - Write to 0x08 → AFU_ID_L unchanged, err_sticky=0.
- **Pipelined reads:** 4 consecutive single-cycle reads of 0x20, 0x28, 0x00, 0x60 → 4 consecutive readdatavalid pulses in order; last data=0 and err_sticky=1.
- **Counters and clear:**
  - 3 writes to SCRATCH1 and 2 reads → WR_COUNT=3; the read of RD_COUNT returns 2.
  - Write 0x40 data=2 be=01 → WR_COUNT=0 and RD_COUNT=0 on the next read; ctrl_enable=0.
- **Wrap and collision:**
  - Force WR_COUNT=0xFFFF_FFFF, then one write → 0.
  - Assert read+write together to 0x20 → write applied, no readdatavalid, err_sticky=1.
- **Async reset mid-read:** assert reset_n=0 one cycle after read acceptance → readdatavalid never pulses; SCRATCH regs=0 after release.
